// File: rtl/button_debounce_bank.sv
// Multi-channel push-button conditioner: synchroniser, stability-window debounce,
// registered press/release strobes. Define BUTTON_DEBOUNCE_BANK_AUTOREPEAT_EN for held-button auto-repeat.
module button_debounce_bank #(
   parameter int N_CH          = 4,
   parameter int STABLE_CNT    = 50000,
   parameter int SYNC_STAGES   = 2,
   parameter int REPEAT_DELAY  = 25000000,
   parameter int REPEAT_PERIOD = 5000000
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [N_CH-1:0] btn_in,
   output logic [N_CH-1:0] btn_level,
   output logic [N_CH-1:0] btn_press,
   output logic [N_CH-1:0] btn_release
);

   localparam int CW = $clog2(STABLE_CNT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);

`ifdef BUTTON_DEBOUNCE_BANK_AUTOREPEAT_EN
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW   = $clog2(RMAX + 1);
   localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);
`endif

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q;
      logic [CW-1:0]          cnt;
      logic                   level_q;
      logic                   press_q;
      logic                   release_q;
      logic                   sync;
      logic                   flip;

      assign sync = sync_q[SYNC_STAGES-1];
      // flip is true on the edge that completes a full window of disagreement
      assign flip = (sync != level_q) && (cnt == CNT_LAST);

      assign btn_level[i]   = level_q;
      assign btn_press[i]   = press_q;
      assign btn_release[i] = release_q;

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            sync_q    <= '0;
            cnt       <= '0;
            level_q   <= 1'b0;
            release_q <= 1'b0;
         end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], btn_in[i]};
            release_q <= flip & ~sync;
            if (sync == level_q) begin
               cnt <= '0;
            end else if (cnt == CNT_LAST) begin
               level_q <= sync;
               cnt     <= '0;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end
      end

`ifdef BUTTON_DEBOUNCE_BANK_AUTOREPEAT_EN
      logic [RW-1:0] rpt_cnt;
      logic          rpt_first;
      logic          rpt_hit;
      logic          rpt_fire;

      assign rpt_hit  = rpt_first ? (rpt_cnt == DELAY_LAST) : (rpt_cnt == PERIOD_LAST);
      // A falling flip wins over a due repeat so nothing coincides with release
      assign rpt_fire = level_q && !flip && rpt_hit;

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
            press_q   <= 1'b0;
         end else begin
            press_q <= (flip & sync) | rpt_fire;
            if (flip || !level_q) begin
               rpt_cnt   <= '0;
               rpt_first <= 1'b1;
            end else if (rpt_hit) begin
               rpt_cnt   <= '0;
               rpt_first <= 1'b0;
            end else begin
               rpt_cnt <= rpt_cnt + RW'(1);
            end
         end
      end
`else
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            press_q <= 1'b0;
         end else begin
            press_q <= flip & sync;
         end
      end
`endif
   end

endmodule

// File: tb/tb_button_debounce_bank.sv
// Directed bench for button_debounce_bank (N_CH=2, STABLE_CNT=4, SYNC_STAGES=2).
module tb_button_debounce_bank;

   logic       clk;
   logic       reset_n;
   logic [1:0] btn_in;
   logic [1:0] btn_level;
   logic [1:0] btn_press;
   logic [1:0] btn_release;

   int n_chk  = 0;
   int n_fail = 0;

`ifdef BUTTON_DEBOUNCE_BANK_AUTOREPEAT_EN
   localparam logic [1:0] RPT = 2'b11;
`else
   localparam logic [1:0] RPT = 2'b00;
`endif

   button_debounce_bank #(
      .N_CH(2), .STABLE_CNT(4), .SYNC_STAGES(2), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
   ) dut (
      .clk(clk), .reset_n(reset_n), .btn_in(btn_in),
      .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk3(input string tag, input logic [1:0] lv, input logic [1:0] pr,
                       input logic [1:0] rl);
      chk({tag, ".level"}, btn_level, lv);
      chk({tag, ".press"}, btn_press, pr);
      chk({tag, ".release"}, btn_release, rl);
   endtask

   initial begin
      // reset held with both buttons pressed
      reset_n = 1'b0;
      btn_in  = 2'b11;
      #23;
      chk3("reset_hold", 2'b00, 2'b00, 2'b00);
      tick(1);
      reset_n = 1'b1;
      tick(5);
      chk3("rst_rel_e5", 2'b00, 2'b00, 2'b00);
      tick(1);
      chk3("rst_rel_e6", 2'b11, 2'b11, 2'b00);
      tick(1);
      chk3("rst_rel_e7", 2'b11, 2'b00, 2'b00);

      // simultaneous release on both channels
      btn_in = 2'b00;
      tick(5);
      chk3("rel_both_e5", 2'b11, 2'b00, 2'b00);
      tick(1);
      chk3("rel_both_e6", 2'b00, 2'b00, 2'b11);
      tick(1);
      chk3("rel_both_e7", 2'b00, 2'b00, 2'b00);

      // clean press on ch0 only
      btn_in = 2'b01;
      tick(5);
      chk3("press0_e5", 2'b00, 2'b00, 2'b00);
      tick(1);
      chk3("press0_e6", 2'b01, 2'b01, 2'b00);
      tick(1);
      chk3("press0_e7", 2'b01, 2'b00, 2'b00);
      btn_in = 2'b00;
      tick(6);
      chk3("rel0_e6", 2'b00, 2'b00, 2'b01);
      tick(1);
      chk3("rel0_e7", 2'b00, 2'b00, 2'b00);

      // bounce: 1,1,1,0 repeating never gives four stable synced cycles
      for (int k = 0; k < 16; k++) begin
         btn_in = (k % 4 == 3) ? 2'b00 : 2'b01;
         tick(1);
         chk3("bounce", 2'b00, 2'b00, 2'b00);
      end
      btn_in = 2'b01;
      tick(5);
      chk3("bounce_hold_e5", 2'b00, 2'b00, 2'b00);
      tick(1);
      chk3("bounce_hold_e6", 2'b01, 2'b01, 2'b00);
      tick(1);
      btn_in = 2'b00;
      tick(6);
      chk3("bounce_rel_e6", 2'b00, 2'b00, 2'b01);
      tick(1);

      // ch1 debounced high, then reset in the middle of ch0's window
      btn_in = 2'b10;
      tick(6);
      chk3("ch1_up", 2'b10, 2'b10, 2'b00);
      btn_in = 2'b11;
      tick(4);
      reset_n = 1'b0;
      #2;
      chk3("mid_reset", 2'b00, 2'b00, 2'b00);
      #3;
      reset_n = 1'b1;
      tick(5);
      chk3("post_rst_e5", 2'b00, 2'b00, 2'b00);
      tick(1);
      chk3("post_rst_e6", 2'b11, 2'b11, 2'b00);

      // held: repeats at t0+10, +13, +16, +19 only with auto-repeat built in
      tick(1);
      chk3("hold_t1", 2'b11, 2'b00, 2'b00);
      tick(8);
      chk3("hold_t9", 2'b11, 2'b00, 2'b00);
      tick(1);
      chk3("hold_t10", 2'b11, RPT, 2'b00);
      tick(1);
      chk3("hold_t11", 2'b11, 2'b00, 2'b00);
      tick(2);
      chk3("hold_t13", 2'b11, RPT, 2'b00);
      tick(2);
      chk("hold_t15.press", btn_press, 2'b00);
      tick(1);
      chk3("hold_t16", 2'b11, RPT, 2'b00);
      btn_in = 2'b00;
      tick(2);
      chk("hold_t18.press", btn_press, 2'b00);
      tick(1);
      chk3("hold_t19", 2'b11, RPT, 2'b00);
      tick(2);
      chk3("hold_t21", 2'b11, 2'b00, 2'b00);
      // release lands where the next repeat would have been due
      tick(1);
      chk3("hold_rel_t22", 2'b00, 2'b00, 2'b11);
      for (int k = 0; k < 12; k++) begin
         tick(1);
         chk3("after_rel", 2'b00, 2'b00, 2'b00);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
